// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: program-memory port, stall-control handshake and trace outputs.
// master = the fetch unit, slave = memory / stall-control side.
interface instruction_fetch_unit_if #(
  parameter int unsigned PC_WIDTH  = 8,
  parameter int unsigned INS_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [PC_WIDTH-1:0]  pm_addr;
  logic [INS_WIDTH-1:0] pm_data;
  logic [INS_WIDTH-1:0] ins;
  logic                 Stall;
  logic                 Stall_pm;
  logic [PC_WIDTH-1:0]  pc_out;
  logic                 halted;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    input  pm_data, Stall, Stall_pm,
    output pm_addr, ins, pc_out, halted, stall_cycles
  );

  modport slave (
    output pm_data, Stall, Stall_pm,
    input  pm_addr, ins, pc_out, halted, stall_cycles
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC + instruction register, with LD/JMP bubble insertion and HLT freeze.
// All outputs come straight from registers; Stall only steers next-state logic.
module instruction_fetch_unit #(
  parameter int unsigned         PC_WIDTH  = 8,
  parameter int unsigned         INS_WIDTH = 24,
  parameter logic [INS_WIDTH-1:0] NOP_WORD = '0,
  parameter int unsigned         CNT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [INS_WIDTH-1:0] ir_q, ir_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_hlt;
  logic is_jmp;

  assign is_hlt = (ir_q[23:19] == 5'b10001);
  assign is_jmp = (ir_q[23:21] == 3'b111);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: HALT is only left through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.Stall && is_hlt) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Output/action logic: PC and IR updates per state
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    unique case (state_q)
      StRun: begin
        if (!bus.Stall) begin
          ir_d = bus.pm_data;
          pc_d = pc_q + PC_WIDTH'(1);
        end else if (is_hlt) begin
          pc_d = pc_q;
          ir_d = ir_q;
        end else if (is_jmp) begin
          pc_d = ir_q[PC_WIDTH-1:0];
          ir_d = NOP_WORD;
        end else begin
          ir_d = NOP_WORD;
        end
      end
      default: begin
        pc_d = pc_q;
        ir_d = ir_q;
      end
    endcase
  end

  // Saturating count of delayed-stall cycles, live in both states
  always_comb begin
    cnt_d = cnt_q;
    if (bus.Stall_pm && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= NOP_WORD;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.pm_addr      = pc_q;
  assign bus.pc_out       = pc_q;
  assign bus.ins          = ir_q;
  assign bus.halted       = (state_q == StHalt);
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: two fetch units (16-bit and 4-bit stall counters) run in lockstep
// against one program image and a behavioural stall-control model.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  logic pm_override;
  logic [23:0] mem [256];
  logic spm1, spm2;

  int n_checks;
  int n_errors;

  instruction_fetch_unit_if #(.PC_WIDTH(8), .INS_WIDTH(24), .CNT_WIDTH(16)) bus1 ();
  instruction_fetch_unit_if #(.PC_WIDTH(8), .INS_WIDTH(24), .CNT_WIDTH(4))  bus2 ();

  instruction_fetch_unit #(
    .PC_WIDTH(8), .INS_WIDTH(24), .NOP_WORD(24'h000000), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  instruction_fetch_unit #(
    .PC_WIDTH(8), .INS_WIDTH(24), .NOP_WORD(24'h000000), .CNT_WIDTH(4)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  function automatic logic stall_of(input logic [23:0] w);
    return (w[23:19] == 5'b10001) || (w[23:21] == 3'b111) || (w[23:19] == 5'b10100);
  endfunction

  assign bus1.pm_data  = pm_override ? 24'hABCDEF : mem[bus1.pm_addr];
  assign bus2.pm_data  = pm_override ? 24'hABCDEF : mem[bus2.pm_addr];
  assign bus1.Stall    = stall_of(bus1.ins);
  assign bus2.Stall    = stall_of(bus2.ins);
  assign bus1.Stall_pm = spm1;
  assign bus2.Stall_pm = spm2;

  always_ff @(posedge clk) begin
    if (reset) begin
      spm1 <= 1'b0;
      spm2 <= 1'b0;
    end else begin
      spm1 <= bus1.Stall;
      spm2 <= bus2.Stall;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, " ins"},     32'(bus1.ins), 32'h000000);
    check_eq({tag, " pm_addr"}, 32'(bus1.pm_addr), 32'h00);
    check_eq({tag, " pc_out"},  32'(bus1.pc_out), 32'h00);
    check_eq({tag, " halted"},  32'(bus1.halted), 32'h0);
    check_eq({tag, " cnt"},     32'(bus1.stall_cycles), 32'h0);
    check_eq({tag, " cnt4"},    32'(bus2.stall_cycles), 32'h0);
    check_eq({tag, " halted4"}, 32'(bus2.halted), 32'h0);
  endtask

  // Expected IR / PC after edges 1..14 following reset release
  logic [23:0] exp_ins [14];
  logic [7:0]  exp_pc  [14];

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    pm_override = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
    mem[0]     = 24'h010000;
    mem[1]     = 24'h020000;
    mem[2]     = 24'h030000;
    mem[3]     = 24'h040000;
    mem[4]     = 24'hA00000;
    mem[5]     = 24'h050000;
    mem[6]     = 24'hE00040;
    mem[7]     = 24'h070000;
    mem[8]     = 24'h080000;
    mem[9]     = 24'h880000;
    mem[8'h40] = 24'h400000;
    mem[8'h41] = 24'hE00008;

    exp_ins = '{24'h010000, 24'h020000, 24'h030000, 24'h040000, 24'hA00000, 24'h000000,
                24'h050000, 24'hE00040, 24'h000000, 24'h400000, 24'hE00008, 24'h000000,
                24'h080000, 24'h880000};
    exp_pc  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05, 8'h06, 8'h07, 8'h40, 8'h41,
                8'h42, 8'h08, 8'h09, 8'h0A};

    // T1: reset with garbage on the memory bus
    do_reset();
    check_cleared("t1");
    pm_override = 1'b0;

    // T2-T4: sequential fetch, LD bubble, JMP redirect and return, reach HLT
    for (int e = 0; e < 14; e++) begin
      step();
      check_eq($sformatf("fetch e%0d ins", e + 1), 32'(bus1.ins), 32'(exp_ins[e]));
      check_eq($sformatf("fetch e%0d pc", e + 1), 32'(bus1.pm_addr), 32'(exp_pc[e]));
      check_eq($sformatf("fetch e%0d halted", e + 1), 32'(bus1.halted), 32'h0);
      if (e == 6)  check_eq("ld bubble cnt", 32'(bus1.stall_cycles), 32'd1);
      if (e == 9)  check_eq("jmp bubble cnt", 32'(bus1.stall_cycles), 32'd2);
      if (e == 12) check_eq("jmp2 bubble cnt", 32'(bus1.stall_cycles), 32'd3);
    end

    // T5/T6: HALT freeze, counter increments, 4-bit counter saturates
    for (int k = 0; k <= 20; k++) begin
      step();
      check_eq($sformatf("halt k%0d halted", k), 32'(bus1.halted), 32'h1);
      check_eq($sformatf("halt k%0d pc", k), 32'(bus1.pm_addr), 32'h0A);
      check_eq($sformatf("halt k%0d ins", k), 32'(bus1.ins), 32'h880000);
      check_eq($sformatf("halt k%0d cnt", k), 32'(bus1.stall_cycles), 32'(3 + k));
      check_eq($sformatf("halt k%0d cnt4", k), 32'(bus2.stall_cycles),
               (3 + k > 15) ? 32'hF : 32'(3 + k));
    end

    // Reset out of HALT, then PC wrap via a jump to 8'hFF
    mem[0]     = 24'hE000FF;
    mem[8'hFF] = 24'h120000;
    do_reset();
    check_cleared("halt reset");

    step();
    check_eq("wrap e1 ins", 32'(bus1.ins), 32'hE000FF);
    check_eq("wrap e1 pc", 32'(bus1.pm_addr), 32'h01);
    step();
    check_eq("wrap e2 ins", 32'(bus1.ins), 32'h000000);
    check_eq("wrap e2 pc", 32'(bus1.pm_addr), 32'hFF);
    step();
    check_eq("wrap e3 ins", 32'(bus1.ins), 32'h120000);
    check_eq("wrap e3 pc", 32'(bus1.pm_addr), 32'h00);
    check_eq("wrap e3 pc4", 32'(bus2.pm_addr), 32'h00);
    check_eq("wrap e3 pc_out", 32'(bus1.pc_out), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
